spi_slave: RTL
==============

// Module: spi_slave
// PURPOSE
//  SPI responder: the far end of the SPI master's shift-register datapath.
//  - Oversamples the master's sclk/mosi/ss_n in the system clk domain.
//  - Shifts received bits into rx_data and drives a preloaded byte out on miso.
//  - Exposes valid/ready byte handshakes to local logic. Sits between the SPI pins and a local register file or FIFO.
// PARAMETERS
//  DATA_W    8      bits per frame
//  CPOL      0      sclk idle level
//  CPHA      0      0: sample on leading edge, shift on trailing; 1: shift on leading, sample on trailing
//  MSB_FIRST 1      1: MSB transmitted and received first; 0: LSB first
//  IDLE_BYTE 8'hFF  byte shifted out when no tx byte is held at frame start
// PORTS
//  clk        in   1       system clock; all logic on posedge; f_clk >= 8*f_sclk
//  rst        in   1       synchronous reset, active-high
//  sclk       in   1       SPI clock from master (asynchronous)
//  ss_n       in   1       slave select, active-low (asynchronous)
//  mosi       in   1       master-out data (asynchronous)
//  miso       out  1       slave-out data
//  miso_oe    out  1       miso output enable; pad tristates when 0
//  tx_data    in   DATA_W  byte to send in the next frame
//  tx_valid   in   1       tx_data valid
//  tx_ready   out  1       tx holding register empty
//  rx_data    out  DATA_W  last received byte
//  rx_valid   out  1       rx_data valid; held until accepted
//  rx_ready   in   1       consumer accepts rx_data
//  busy       out  1       frame in progress (ss_n asserted)
// BEHAVIOUR
//  - Reset (sync, active-high):
//    - miso=0, miso_oe=0, tx_ready=1, rx_valid=0, rx_data=0, busy=0.
//    - Bit counter=0; FSM=IDLE.
//  - Input synchronisation:
//    - sclk, ss_n and mosi each pass through a 2-flop synchroniser.
//    - Edges are detected on the synchronised sclk.
//    - Pin-to-internal latency is 3 clk.
//  - Edge definitions:
//    - Leading edge = sclk leaving CPOL level; trailing edge = sclk returning to CPOL level.
//    - Sample edge = leading if CPHA=0, else trailing.
//    - Shift edge = the opposite edge.
//  - TX holding register:
//    - tx_valid & tx_ready loads tx_data and drops tx_ready.
//    - Frame start copies the holding register into the shifter and sets tx_ready=1.
//    - If the holding register is empty at frame start, the shifter loads IDLE_BYTE.
//  - FSM IDLE:
//    - miso_oe=0, busy=0.
//    - ss_n falling (synchronised) -> LOAD.
//  - FSM LOAD (1 clk):
//    - Load the shifter; bit counter=0; miso_oe=1; busy=1.
//    - If CPHA=0, drive the first bit on miso this cycle.
//    - -> SHIFT.
//  - FSM SHIFT:
//    - Sample edge: shift mosi into the rx shifter; bit counter +1.
//    - Shift edge: advance the tx shifter and update miso.
//    - If CPHA=0, there is no shift on the trailing edge that follows the final sample.
//    - When the counter reaches DATA_W -> DONE.
//  - FSM DONE (1 clk):
//    - Write rx_data and set rx_valid=1.
//    - If ss_n is still low, reload the shifter (as in LOAD), reset the counter, and go back to SHIFT for back-to-back frames.
//    - Otherwise -> IDLE.
//  - rx_valid & rx_ready clears rx_valid the next clk.
//    - A new DONE in the same cycle as an accept wins: rx_valid stays 1 with the new data.
//  - ss_n rises mid-frame (from any state):
//    - Abort -> IDLE next clk; partial byte discarded; no rx_valid.
//    - The holding register is unaffected if it was not yet consumed.
//  - rst mid-frame: immediate return to reset values; the master sees miso released (miso_oe=0).
//  - sclk edges while ss_n is high are ignored.
// CONFIGURATION
//  - SPI_SLAVE_OVERRUN_EN defined:
//    - Adds output rx_overrun (1 bit, reset 0).
//    - Set on DONE while rx_valid=1 and not being accepted that cycle.
//    - Sticky; cleared only by rst or by rx_valid & rx_ready.
//    - rx_data is still overwritten.
//  - Macro undefined: the port is absent and overwrite is silent.
// STRUCTURE
//  - Package spi_pkg: FSM state typedef (IDLE, LOAD, SHIFT, DONE); SPI_DATA_W=8; SPI_IDLE_BYTE=8'hFF.
//  - Sub-module spi_sync_edge: 2-flop synchroniser plus rise/fall pulse outputs.
//    - Instanced for sclk and ss_n; for mosi, synchroniser only.
// TESTING
//  1. Reset, then mode 0:
//     - Stimulus: master sends 8'h8E; tx_data=8'h11 preloaded.
//     - Response: rx_data=8'h8E with rx_valid=1 after ss_n rises; master captures 8'h11.
//  2. No tx preload:
//     - Stimulus: master sends 8'h3C.
//     - Response: master captures 8'hFF; rx_data=8'h3C.
//  3. Back-to-back frames:
//     - Stimulus: ss_n held low for 16 sclk; master sends 8'hA5, 8'h5A; tx loads 8'h01 then 8'h02 (after tx_ready re-asserts).
//     - Response: two accepted rx bytes 8'hA5, 8'h5A; master sees 8'h01, 8'h02.
//  4. Abort:
//     - Stimulus: ss_n deasserted after 4 sclk.
//     - Response: no rx_valid; miso_oe=0 within 4 clk; next full frame receives correctly.
//  5. Modes 1, 2 and 3: byte 8'hC3 loopback; rx and tx match in each mode.
//  6. With SPI_SLAVE_OVERRUN_EN: two frames with rx_ready=0.
//     - Response: rx_overrun=1; rx_data=second byte; accept clears rx_overrun.

Source files
------------

// File: rtl/spi_pkg.sv
//------------------------------------------------------------------------------
// Module      : spi_pkg
// Description : Shared constants and FSM state type for the SPI responder.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package spi_pkg;

  localparam int SPI_DATA_W = 8;
  localparam logic [SPI_DATA_W-1:0] SPI_IDLE_BYTE = 8'hFF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } spi_state_e;

endpackage

`default_nettype wire

// File: rtl/spi_slave_if.sv
//------------------------------------------------------------------------------
// Module      : spi_slave_if
// Description : SPI pins plus local tx/rx byte handshakes of the SPI responder.
//               SPI_SLAVE_OVERRUN_EN adds the sticky rx_overrun flag.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface spi_slave_if
  import spi_pkg::*;
#(
  parameter int DATA_W = SPI_DATA_W
);

  logic              sclk;
  logic              ss_n;
  logic              mosi;
  logic              miso;
  logic              miso_oe;
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              busy;
`ifdef SPI_SLAVE_OVERRUN_EN
  logic              rx_overrun;
`endif

  modport slave (
    input  sclk, ss_n, mosi, tx_data, tx_valid, rx_ready,
    output miso, miso_oe, tx_ready, rx_data, rx_valid, busy
`ifdef SPI_SLAVE_OVERRUN_EN
    , output rx_overrun
`endif
  );

  modport master (
    output sclk, ss_n, mosi, tx_data, tx_valid, rx_ready,
    input  miso, miso_oe, tx_ready, rx_data, rx_valid, busy
`ifdef SPI_SLAVE_OVERRUN_EN
    , input rx_overrun
`endif
  );

endinterface

`default_nettype wire

// File: rtl/spi_sync_edge.sv
//------------------------------------------------------------------------------
// Module      : spi_sync_edge
// Description : Two-flop synchroniser for an asynchronous pin with level and
//               single-cycle rise/fall pulses on the synchronised value.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module spi_sync_edge #(
  parameter bit RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d_in,
  output logic level,
  output logic rise,
  output logic fall
);

  // [0] metastable stage, [1] synchronised level, [2] previous level
  logic [2:0] sync_q, sync_d;

  always_comb begin
    sync_d = {sync_q[1:0], d_in};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= {3{RST_VAL}};
    end else begin
      sync_q <= sync_d;
    end
  end

  assign level = sync_q[1];
  assign rise  = sync_q[1] & ~sync_q[2];
  assign fall  = ~sync_q[1] & sync_q[2];

endmodule

`default_nettype wire

// File: rtl/spi_slave.sv
//------------------------------------------------------------------------------
// Module      : spi_slave
// Description : Oversampling SPI responder with tx holding register and rx
//               valid/ready handshake. SPI_SLAVE_OVERRUN_EN adds rx_overrun.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module spi_slave
  import spi_pkg::*;
#(
  parameter int                DATA_W    = SPI_DATA_W,
  parameter bit                CPOL      = 1'b0,
  parameter bit                CPHA      = 1'b0,
  parameter bit                MSB_FIRST = 1'b1,
  parameter logic [DATA_W-1:0] IDLE_BYTE = SPI_IDLE_BYTE
) (
  input logic        clk,
  input logic        rst,
  spi_slave_if.slave bus
);

  localparam int             CNT_W    = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W);

  logic sclk_lvl, sclk_rise, sclk_fall;
  logic ss_lvl, ss_rise, ss_fall;

  spi_sync_edge #(.RST_VAL(CPOL)) u_sclk_sync (
    .clk(clk), .rst(rst), .d_in(bus.sclk),
    .level(sclk_lvl), .rise(sclk_rise), .fall(sclk_fall)
  );

  spi_sync_edge #(.RST_VAL(1'b1)) u_ss_sync (
    .clk(clk), .rst(rst), .d_in(bus.ss_n),
    .level(ss_lvl), .rise(ss_rise), .fall(ss_fall)
  );

  spi_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] tx_sh_q, tx_sh_d, rx_sh_q, rx_sh_d;
  logic [DATA_W-1:0] hold_q, hold_d, rx_data_q, rx_data_d;
  logic [1:0]        mosi_sync_q, mosi_sync_d;
  logic              hold_full_q, hold_full_d;
  logic              rx_valid_q, rx_valid_d;
  logic              miso_q, miso_d;

  logic              sclk_edge, lead_edge, trail_edge, sample_edge, shift_edge;
  logic              abort, reload, rx_accept;
  logic [DATA_W-1:0] frame_byte;

  function automatic logic head_bit(input logic [DATA_W-1:0] v);
    return MSB_FIRST ? v[DATA_W-1] : v[0];
  endfunction

  function automatic logic [DATA_W-1:0] advance(input logic [DATA_W-1:0] v);
    return MSB_FIRST ? (v << 1) : (v >> 1);
  endfunction

  function automatic logic [DATA_W-1:0] shift_in(input logic [DATA_W-1:0] v, input logic b);
    return MSB_FIRST ? {v[DATA_W-2:0], b} : {b, v[DATA_W-1:1]};
  endfunction

  assign sclk_edge   = sclk_rise | sclk_fall;
  assign lead_edge   = sclk_edge & (sclk_lvl != CPOL);
  assign trail_edge  = sclk_edge & (sclk_lvl == CPOL);
  assign sample_edge = CPHA ? trail_edge : lead_edge;
  assign shift_edge  = CPHA ? lead_edge : trail_edge;
  assign frame_byte  = hold_full_q ? hold_q : IDLE_BYTE;
  assign rx_accept   = rx_valid_q & bus.rx_ready;
  assign abort       = ss_rise & ((state_q == LOAD) | (state_q == SHIFT));

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    tx_sh_d     = tx_sh_q;
    rx_sh_d     = rx_sh_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = rx_valid_q;
    miso_d      = miso_q;
    mosi_sync_d = {mosi_sync_q[0], bus.mosi};
    reload      = 1'b0;

    case (state_q)
      IDLE: begin
        miso_d = 1'b0;
        if (ss_fall) state_d = LOAD;
      end
      LOAD: begin
        reload  = 1'b1;
        state_d = SHIFT;
      end
      SHIFT: begin
        if (sample_edge) begin
          rx_sh_d = shift_in(rx_sh_q, mosi_sync_q[1]);
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == CNT_LAST - 1'b1) state_d = DONE;
        end
        // In mode CPHA=0 the trailing edge after a frame's last sample must
        // not disturb the first bit already presented for the next frame.
        if (shift_edge && (CPHA || (cnt_q != '0))) begin
          miso_d  = head_bit(tx_sh_q);
          tx_sh_d = advance(tx_sh_q);
        end
      end
      DONE: begin
        rx_data_d = rx_sh_q;
        if (!ss_lvl) begin
          reload  = 1'b1;
          state_d = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (abort) state_d = IDLE;

    if (reload && !abort) begin
      cnt_d       = '0;
      hold_full_d = 1'b0;
      if (CPHA) begin
        tx_sh_d = frame_byte;
      end else begin
        miso_d  = head_bit(frame_byte);
        tx_sh_d = advance(frame_byte);
      end
    end

    if (bus.tx_valid && !hold_full_q) begin
      hold_d      = bus.tx_data;
      hold_full_d = 1'b1;
    end

    if (rx_accept)         rx_valid_d = 1'b0;
    if (state_q == DONE)   rx_valid_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      tx_sh_q     <= '0;
      rx_sh_q     <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      miso_q      <= 1'b0;
      mosi_sync_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      tx_sh_q     <= tx_sh_d;
      rx_sh_q     <= rx_sh_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      miso_q      <= miso_d;
      mosi_sync_q <= mosi_sync_d;
    end
  end

  assign bus.miso     = miso_q;
  assign bus.miso_oe  = (state_q != IDLE);
  assign bus.busy     = (state_q != IDLE);
  assign bus.tx_ready = ~hold_full_q;
  assign bus.rx_data  = rx_data_q;
  assign bus.rx_valid = rx_valid_q;

`ifdef SPI_SLAVE_OVERRUN_EN
  logic overrun_q, overrun_d;

  always_comb begin
    overrun_d = overrun_q;
    if (rx_accept) overrun_d = 1'b0;
    if ((state_q == DONE) && rx_valid_q && !bus.rx_ready) overrun_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      overrun_q <= 1'b0;
    end else begin
      overrun_q <= overrun_d;
    end
  end

  assign bus.rx_overrun = overrun_q;
`else
  // Without the overrun flag a second DONE silently replaces an unread byte.
`endif

endmodule

`default_nettype wire
